// File: rtl/instr_in_buffer.sv
// Ingress FIFO for fetched instruction words ahead of the decoder, with taken-branch flush.
// Ports: clk, rst_n, in_* (fetch side), flush, out_* (decoder side), level.
// Optional INBUF_STATS_EN adds the flush_drops and stall_cycles counters.
module instr_in_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   level
`ifdef INBUF_STATS_EN
  ,
  output logic [15:0]     flush_drops,
  output logic [15:0]     stall_cycles
`endif
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  logic [2*XLEN-1:0] head;

  assign in_ready  = (count_q != CW'(DEPTH)) & ~flush;
  assign out_valid = (count_q != '0);
  assign level     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  assign out_instr = out_valid ? head[2*XLEN-1:XLEN] : NOP;
  assign out_pc    = out_valid ? head[XLEN-1:0] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // push is already blocked by in_ready; any pop is dropped
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_instr, in_pc};
  end

`ifdef INBUF_STATS_EN
  logic [15:0] flush_drops_q, flush_drops_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [16:0] fd_sum;

  always_comb begin
    flush_drops_d  = flush_drops_q;
    stall_cycles_d = stall_cycles_q;
    fd_sum = {1'b0, flush_drops_q} + 17'(count_q);
    if (flush)
      flush_drops_d = fd_sum[16] ? 16'hFFFF : fd_sum[15:0];
    if (in_valid && !in_ready && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_drops_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      flush_drops_q  <= flush_drops_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign flush_drops  = flush_drops_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_instr_in_buffer.sv
// Scoreboard bench for instr_in_buffer: stimulus pushes expected words,
// a negedge monitor compares the head entry against the queue.
module tb_instr_in_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  level;
`ifdef INBUF_STATS_EN
  logic [15:0] flush_drops, stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;
  int mcount   = 0;
  logic [63:0] expq[$];

  always #5 clk = ~clk;

  instr_in_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .level(level)
`ifdef INBUF_STATS_EN
    , .flush_drops(flush_drops),
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: head must match scoreboard; pop on consumption
  always @(negedge clk) begin
    if (run) begin
      chk("out_valid", 64'(out_valid), 64'(expq.size() != 0));
      if (out_valid) begin
        if (expq.size() != 0) begin
          chk("head_word", {out_instr, out_pc}, expq[0]);
          if (out_ready && !flush) void'(expq.pop_front());
        end
      end else begin
        chk("idle_instr", 64'(out_instr), 64'(NOP));
        chk("idle_pc", 64'(out_pc), 64'd0);
      end
    end
  end

  // one cycle of stimulus; called at posedge+1
  task automatic cyc(bit iv, logic [31:0] ins, logic [31:0] pc,
                     bit ordy, bit fl);
    bit exp_rdy, psh, pp;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    exp_rdy = (mcount != DEPTH) && !fl;
    psh = iv && exp_rdy;
    pp  = (mcount != 0) && ordy && !fl;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("level", 64'(level), 64'(mcount));
    @(posedge clk);
    #1;
    if (fl) begin
      mcount = 0;
      expq.delete();
    end else begin
      if (psh) expq.push_back({ins, pc});
      mcount = mcount + int'(psh) - int'(pp);
    end
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

`ifdef INBUF_STATS_EN
  logic [15:0] fd0, st0;
`endif

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;

    // reset state
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_instr", 64'(out_instr), 64'(NOP));

    // single word, held until consumed
    cyc(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("hold_instr", 64'(out_instr), 64'h0050_0093);
    chk("hold_pc", 64'(out_pc), 64'h0);
    chk("hold_level", 64'(level), 64'd1);
    idle(2, 1'b1);

    // fill to DEPTH, refuse 5th, drain in order
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    chk("full_level", 64'(level), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
`ifdef INBUF_STATS_EN
    st0 = stall_cycles;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'hEE, 32'hEE, 1'b0, 1'b0);
    chk("stall_cycles", 64'(stall_cycles - st0), 64'd5);
`endif
    // push blocked even while popping at full
    cyc(1'b1, 32'hBAD, 32'h0, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("drained_level", 64'(level), 64'd0);

    // steady push+pop at level 2 across pointer wrap
    cyc(1'b1, 32'hC0, 32'h200, 1'b0, 1'b0);
    cyc(1'b1, 32'hC1, 32'h204, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++)
      cyc(1'b1, 32'hC0 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
    chk("stream_level", 64'(level), 64'd2);
    idle(2, 1'b1);

    // flush at level 3 with in_valid high
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'hD0 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
`ifdef INBUF_STATS_EN
    fd0 = flush_drops;
`endif
    cyc(1'b1, 32'hDEAD, 32'h0, 1'b1, 1'b1);
    chk("post_flush_level", 64'(level), 64'd0);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
`ifdef INBUF_STATS_EN
    chk("flush_drops", 64'(flush_drops - fd0), 64'd3);
`endif
    // back-to-back flush keeps it empty
    cyc(1'b1, 32'hDEAD, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0513, 32'h400, 1'b0, 1'b0);
    chk("redir_instr", 64'(out_instr), 64'h0000_0513);
    chk("redir_pc", 64'(out_pc), 64'h400);
    idle(1, 1'b1);

    // reset mid-transfer
    cyc(1'b1, 32'hE0, 32'h500, 1'b0, 1'b0);
    cyc(1'b1, 32'hE1, 32'h504, 1'b0, 1'b0);
    rst_n = 1'b0;
    mcount = 0;
    expq.delete();
    #2;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_instr", 64'(out_instr), 64'(NOP));
    chk("rst_mid_level", 64'(level), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);
    chk("rst_ready", 64'(in_ready), 64'd1);
    cyc(1'b1, 32'hF0, 32'h600, 1'b1, 1'b0);
    idle(2, 1'b1);

    chk("sb_empty", 64'(expq.size()), 64'd0);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
